// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath constants: widths, register count and N/Z/P condition-code encodings.
package lc3_pkg;

  localparam int unsigned WIDTH     = 16;
  localparam int unsigned NREG      = 8;
  localparam int unsigned REG_IDX_W = 3;

  typedef logic [2:0] cc_t;

  localparam cc_t CC_N   = 3'b100;
  localparam cc_t CC_Z   = 3'b010;
  localparam cc_t CC_P   = 3'b001;
  localparam cc_t CC_RST = CC_Z;

endpackage

// File: rtl/regfile_cc_if.sv
// Bus-sink interface of the register file: bus capture, operand reads, CC and BEN controls.
interface regfile_cc_if #(
  parameter int unsigned WIDTH = lc3_pkg::WIDTH
);
  logic [WIDTH-1:0]              bus;
  logic                          ld_reg;
  logic [lc3_pkg::REG_IDX_W-1:0] dr;
  logic [lc3_pkg::REG_IDX_W-1:0] sr1;
  logic [lc3_pkg::REG_IDX_W-1:0] sr2;
  logic [WIDTH-1:0]              sr1_out;
  logic [WIDTH-1:0]              sr2_out;
  logic                          ld_cc;
  logic                          n;
  logic                          z;
  logic                          p;
  logic                          ld_ben;
  logic [2:0]                    ir_nzp;
  logic                          ben;

  modport master (
    output bus, ld_reg, dr, sr1, sr2, ld_cc, ld_ben, ir_nzp,
    input  sr1_out, sr2_out, n, z, p, ben
  );

  modport slave (
    input  bus, ld_reg, dr, sr1, sr2, ld_cc, ld_ben, ir_nzp,
    output sr1_out, sr2_out, n, z, p, ben
  );
endinterface

// File: rtl/regfile_cc_cc_gen.sv
// Combinational bus -> one-hot {n,z,p} classifier for two's-complement values.
module cc_gen #(
  parameter int unsigned WIDTH = lc3_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] bus,
  output logic [2:0]       cc
);
  import lc3_pkg::CC_N;
  import lc3_pkg::CC_Z;
  import lc3_pkg::CC_P;

  always_comb begin
    cc = CC_P;
    if (bus == '0) begin
      cc = CC_Z;
    end else if (bus[WIDTH-1]) begin
      cc = CC_N;
    end
  end
endmodule

// File: rtl/regfile_cc.sv
// LC-3 bus sink: general register file, N/Z/P condition codes and branch-enable flag.
module regfile_cc #(
  parameter int unsigned     WIDTH   = lc3_pkg::WIDTH,
  parameter int unsigned     NREG    = lc3_pkg::NREG,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic         clk,
  input logic         rst,
  regfile_cc_if.slave rf
);
  import lc3_pkg::cc_t;
  import lc3_pkg::CC_RST;

  logic [WIDTH-1:0] regs_q [NREG];
  cc_t              cc_q;
  cc_t              cc_d;
  logic             ben_q;

  cc_gen #(
    .WIDTH(WIDTH)
  ) u_cc_gen (
    .bus(rf.bus),
    .cc (cc_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= RST_VAL;
      end
    end else if (rf.ld_reg) begin
      regs_q[rf.dr] <= rf.bus;
    end
  end

  // BEN samples cc_q, so a same-cycle ld_cc does not affect it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_q  <= CC_RST;
      ben_q <= 1'b0;
    end else begin
      if (rf.ld_cc) begin
        cc_q <= cc_d;
      end
      if (rf.ld_ben) begin
        ben_q <= |(rf.ir_nzp & cc_q);
      end
    end
  end

  assign rf.sr1_out = regs_q[rf.sr1];
  assign rf.sr2_out = regs_q[rf.sr2];
  assign rf.n       = cc_q[2];
  assign rf.z       = cc_q[1];
  assign rf.p       = cc_q[0];
  assign rf.ben     = ben_q;
endmodule

// File: tb/tb_regfile_cc.sv
// Scoreboard bench for regfile_cc: directed steps queue expected outputs, a monitor compares them.
module tb_regfile_cc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  regfile_cc_if rf ();

  regfile_cc dut (
    .clk(clk),
    .rst(rst),
    .rf (rf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       name;
    logic [15:0] s1;
    logic [15:0] s2;
    logic [2:0]  nzp;
    logic        ben;
  } exp_t;

  exp_t exp_q[$];

  // Loads on an undriven bus are a microcode error.
  always @(posedge clk) begin
    if (!rst && (rf.ld_reg || rf.ld_cc)) begin
      assert (!$isunknown(rf.bus)) else $error("load from undriven bus at cycle %0d", cyc);
    end
  end

  task automatic cmp(input string name, input string what, input logic [15:0] got,
                     input logic [15:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s.%s got %h want %h (cycle %0d)", name, what, got, want, cyc);
    end
  endtask

  // Monitor: outputs are sampled at negedge for every expectation tagged with this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp(e.name, "sr1_out", rf.sr1_out, e.s1);
      cmp(e.name, "sr2_out", rf.sr2_out, e.s2);
      cmp(e.name, "nzp", {13'd0, rf.n, rf.z, rf.p}, {13'd0, e.nzp});
      cmp(e.name, "ben", {15'd0, rf.ben}, {15'd0, e.ben});
    end
  end

  // Drive one cycle of inputs just after the edge and queue the outputs expected before the next.
  task automatic step(input string name, input logic r, input logic lr, input logic [2:0] d,
                      input logic [15:0] b, input logic lc, input logic lb,
                      input logic [2:0] irn, input logic [2:0] s1, input logic [2:0] s2,
                      input logic [15:0] e1, input logic [15:0] e2, input logic [2:0] enzp,
                      input logic eben);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r;
    rf.ld_reg = lr;
    rf.dr     = d;
    rf.bus    = b;
    rf.ld_cc  = lc;
    rf.ld_ben = lb;
    rf.ir_nzp = irn;
    rf.sr1    = s1;
    rf.sr2    = s2;
    e.cyc  = cyc;
    e.name = name;
    e.s1   = e1;
    e.s2   = e2;
    e.nzp  = enzp;
    e.ben  = eben;
    exp_q.push_back(e);
  endtask

  initial begin
    logic [15:0] vi;
    logic [15:0] vj;
    rf.bus = '0; rf.ld_reg = 0; rf.dr = 0; rf.ld_cc = 0; rf.ld_ben = 0;
    rf.ir_nzp = 0; rf.sr1 = 0; rf.sr2 = 0;
    repeat (2) @(posedge clk);

    //   name          rst lr dr  bus       lc lb irn     s1  s2   exp1      exp2      nzp     ben
    step("reset",      0, 0, 0, 16'h0000, 0, 0, 3'b000, 0,  7,  16'h0000, 16'h0000, 3'b010, 0);
    step("wr_same",    0, 1, 3, 16'hBEEF, 0, 0, 3'b000, 3,  4,  16'h0000, 16'h0000, 3'b010, 0);
    step("wr_after",   0, 0, 0, 16'h0000, 0, 0, 3'b000, 3,  4,  16'hBEEF, 16'h0000, 3'b010, 0);
    step("cc_8000",    0, 0, 0, 16'h8000, 1, 0, 3'b000, 3,  3,  16'hBEEF, 16'hBEEF, 3'b010, 0);
    step("cc_0000",    0, 0, 0, 16'h0000, 1, 0, 3'b000, 3,  3,  16'hBEEF, 16'hBEEF, 3'b100, 0);
    step("cc_7fff",    0, 0, 0, 16'h7FFF, 1, 0, 3'b000, 3,  3,  16'hBEEF, 16'hBEEF, 3'b010, 0);
    step("cc_0001",    0, 0, 0, 16'h0001, 1, 0, 3'b000, 3,  3,  16'hBEEF, 16'hBEEF, 3'b001, 0);
    step("cc_hold1",   0, 0, 0, 16'h8000, 0, 0, 3'b000, 3,  3,  16'hBEEF, 16'hBEEF, 3'b001, 0);
    step("cc_hold2",   0, 0, 0, 16'h0000, 0, 0, 3'b000, 3,  3,  16'hBEEF, 16'hBEEF, 3'b001, 0);
    step("ben_001",    0, 0, 0, 16'h0000, 0, 1, 3'b001, 3,  0,  16'hBEEF, 16'h0000, 3'b001, 0);
    step("ben_110",    0, 0, 0, 16'h0000, 0, 1, 3'b110, 3,  0,  16'hBEEF, 16'h0000, 3'b001, 1);
    step("ben_000",    0, 0, 0, 16'h0000, 0, 1, 3'b000, 3,  0,  16'hBEEF, 16'h0000, 3'b001, 0);
    step("ben_111",    0, 0, 0, 16'h0000, 0, 1, 3'b111, 3,  0,  16'hBEEF, 16'h0000, 3'b001, 0);
    step("ben_res",    0, 0, 0, 16'h0000, 0, 0, 3'b000, 3,  0,  16'hBEEF, 16'h0000, 3'b001, 1);
    step("pre_z",      0, 0, 0, 16'h0000, 1, 0, 3'b000, 3,  0,  16'hBEEF, 16'h0000, 3'b001, 1);
    step("cc_ben_ovl", 0, 0, 0, 16'h8000, 1, 1, 3'b100, 3,  0,  16'hBEEF, 16'h0000, 3'b010, 1);
    step("ovl_res",    0, 0, 0, 16'h0000, 0, 0, 3'b000, 3,  0,  16'hBEEF, 16'h0000, 3'b100, 0);

    for (int i = 0; i < 8; i++) begin
      step("wr_all", 0, 1, 3'(i), 16'(16'h1111 * i), 0, 0, 3'b000, 0, 0,
           16'h0000, 16'h0000, 3'b100, 0);
    end
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        vi = 16'(16'h1111 * i);
        vj = 16'(16'h1111 * j);
        step("rd_pair", 0, 0, 0, 16'h0000, 0, 0, 3'b000, 3'(i), 3'(j), vi, vj, 3'b100, 0);
      end
    end

    step("ben_set",    0, 0, 0, 16'h0000, 0, 1, 3'b100, 5,  7,  16'h5555, 16'h7777, 3'b100, 0);
    step("pre_rst",    0, 0, 0, 16'h0000, 0, 0, 3'b000, 5,  7,  16'h5555, 16'h7777, 3'b100, 1);
    // Reset asserted mid-cycle with every load active; checked before the next edge.
    step("rst_async",  1, 1, 5, 16'h8234, 1, 1, 3'b111, 5,  7,  16'h0000, 16'h0000, 3'b010, 0);
    step("rst_held",   1, 1, 5, 16'h8234, 1, 1, 3'b111, 5,  7,  16'h0000, 16'h0000, 3'b010, 0);
    step("rst_rel",    0, 1, 5, 16'h1234, 0, 0, 3'b000, 5,  7,  16'h0000, 16'h0000, 3'b010, 0);
    step("post_rst",   0, 0, 0, 16'h0000, 0, 0, 3'b000, 5,  7,  16'h1234, 16'h0000, 3'b010, 0);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
